// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single UART transmitter that
// sends each granted nibble as a Hamming(7,4) codeword, LSB first.
module uart_tx_arbiter #(
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] req,
  input  logic [3:0] nibble0,
  input  logic [3:0] nibble1,
  output logic [1:0] gnt,
  output logic       tx,
  output logic       busy,
  output logic [1:0] state_out,
  output logic [7:0] frame_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(6);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [BIT_W-1:0] bit_idx, bit_idx_n;
  logic [6:0]       code, code_n;
  logic             last_one, last_one_n;   // requester 1 was granted most recently
  logic [7:0]       frame_count_n;
  logic             tx_n;
  logic             win_one;

  function automatic logic [6:0] hamming(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return c;
  endfunction

  // Next-state, grant and serial-bit selection
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    bit_idx_n     = bit_idx;
    code_n        = code;
    last_one_n    = last_one;
    frame_count_n = frame_count;
    gnt           = 2'b00;
    win_one       = req[1] & (~req[0] | ~last_one);

    if (ena && rst_n) begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt        = win_one ? 2'b10 : 2'b01;
            code_n     = hamming(win_one ? nibble1 : nibble0);
            last_one_n = win_one;
            cnt_n      = '0;
            bit_idx_n  = '0;
            state_n    = START;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt_n     = '0;
            bit_idx_n = '0;
            state_n   = DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            if (bit_idx == BIT_LAST) begin
              state_n = STOP;
            end else begin
              bit_idx_n = bit_idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_n         = '0;
            frame_count_n = frame_count + 1'b1;
            state_n       = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      endcase
    end

    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = code_n[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      code        <= '0;
      last_one    <= 1'b1;
      frame_count <= '0;
      tx          <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      code        <= code_n;
      last_one    <= last_one_n;
      frame_count <= frame_count_n;
      tx          <= tx_n;
      busy        <= (state_n != IDLE);
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues issued nibbles, a
// monitor predicts grants and the serial waveform from the frame rules.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int unsigned OS = 8;
  localparam int FRAME_EDGES = 9 * OS + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] req = 2'b00;
  logic [3:0] nibble0 = 4'h0;
  logic [3:0] nibble1 = 4'h0;
  logic [1:0] gnt;
  logic       tx;
  logic       busy;
  logic [1:0] state_out;
  logic [7:0] frame_count;

  int total = 0;
  int bad = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];

  // reference model state, owned by the monitor
  bit         active = 1'b0;
  int         k = 0;
  bit         last_one_m = 1'b1;
  logic [8:0] frame_bits = '1;
  logic [7:0] exp_fc = 8'd0;
  int         frames_done = 0;
  bit         last_ena = 1'b0;

  uart_tx_arbiter #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req),
    .nibble0(nibble0), .nibble1(nibble1), .gnt(gnt), .tx(tx),
    .busy(busy), .state_out(state_out), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] make_frame(input logic [3:0] d);
    logic [6:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    return {1'b1, c, 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: advance the model one clock, compare outputs, predict grants
  initial begin : monitor
    int b;
    logic [1:0] st;
    logic [1:0] eg;
    logic [3:0] nib;
    logic [11:0] exp_o;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0; k = 0; last_one_m = 1'b1; exp_fc = 8'd0;
        frames_done = 0; last_ena = 1'b0;
      end else begin
        if (active && last_ena) k++;
        if (active && k == FRAME_EDGES) begin
          active = 1'b0;
          exp_fc++;
          frames_done++;
        end
        if (active) begin
          b = (k - 1) / OS;
          st = (b == 0) ? 2'd1 : (b == 8) ? 2'd3 : 2'd2;
          exp_o = {frame_bits[b], 1'b1, st, exp_fc};
        end else begin
          exp_o = {1'b1, 1'b0, 2'd0, exp_fc};
        end
        check("outputs", 32'({tx, busy, state_out, frame_count}), 32'(exp_o));

        eg = 2'b00;
        if (!active && ena && req != 2'b00) begin
          if (req == 2'b01)      eg = 2'b01;
          else if (req == 2'b10) eg = 2'b10;
          else                   eg = last_one_m ? 2'b01 : 2'b10;
        end
        check("grant", 32'(gnt), 32'(eg));
        if (eg != 2'b00) begin
          if ((eg[1] && q1.size() == 0) || (eg[0] && q0.size() == 0)) begin
            total++; bad++;
            $display("FAIL nibble_queue: grant %b with no issued request at %0t", eg, $time);
            nib = 4'h0;
          end else begin
            nib = eg[1] ? q1.pop_front() : q0.pop_front();
          end
          frame_bits = make_frame(nib);
          last_one_m = eg[1];
          active = 1'b1;
          k = 0;
        end
        last_ena = ena;
      end
    end
  end

  task automatic run_random(input int cycles, input int ena_pct, input int req_pct, input int wd_pct);
    logic [1:0] g;
    logic [3:0] nib;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (req[i] && g[i]) begin
          req[i] = 1'b0;
        end else if (req[i] && int'($urandom_range(99)) < wd_pct) begin
          req[i] = 1'b0;
          if (i == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        end else if (!req[i] && int'($urandom_range(99)) < req_pct) begin
          nib = 4'($urandom);
          if (i == 0) begin nibble0 = nib; q0.push_back(nib); end
          else        begin nibble1 = nib; q1.push_back(nib); end
          req[i] = 1'b1;
        end
      end
      ena = int'($urandom_range(99)) < ena_pct;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || active) && n < 3000) begin
      run_random(1, 100, 0, 0);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL drain: transmitter still busy after %0d cycles", n);
    end
    @(posedge clk); #1;
    req = 2'b00;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [8:0] exp_bits;
    logic [1:0] g;
    logic [1:0] gseq[3];
    int         gtime[3];
    int         grants;
    int         early;

    // reset state, with requests present to show gnt is suppressed
    repeat (2) @(posedge clk);
    #1; req = 2'b11; ena = 1'b1;
    #1 check("reset_out", 32'({gnt, tx, busy, state_out, frame_count}), 32'({2'b00, 1'b1, 1'b0, 2'd0, 8'd0}));
    @(posedge clk); #1; req = 2'b00; ena = 1'b0;
    #2 rst_n = 1'b1;

    // single frame from requester 0, nibble 1011
    exp_bits = 9'b110101010;
    @(posedge clk); #1; ena = 1'b1; req = 2'b01; nibble0 = 4'b1011; q0.push_back(4'b1011);
    @(negedge clk); check("d1_gnt", 32'(gnt), 32'(2'b01));
    for (int cnt = 1; cnt <= 73; cnt++) begin
      @(posedge clk); #1; req = 2'b00;
      @(negedge clk);
      if (cnt % 8 == 4 && cnt < 72) check("d1_tx", 32'(tx), 32'(exp_bits[cnt / 8]));
      if (cnt == 72) check("d1_before_end", 32'({busy, frame_count}), 32'({1'b1, 8'd0}));
      if (cnt == 73) check("d1_after_end", 32'({busy, frame_count}), 32'({1'b0, 8'd1}));
    end

    // same frame with ena toggling every cycle: each bit spans 16 clocks
    @(posedge clk); #1; ena = 1'b1; req = 2'b01; nibble0 = 4'b1011; q0.push_back(4'b1011);
    @(negedge clk); check("d2_gnt", 32'(gnt), 32'(2'b01));
    for (int cnt = 1; cnt <= 146; cnt++) begin
      @(posedge clk); #1; req = 2'b00; ena = ~ena;
      @(negedge clk);
      if (cnt % 16 == 8 && cnt < 144) check("d2_tx", 32'(tx), 32'(exp_bits[cnt / 16]));
      if (cnt == 144) check("d2_before_end", 32'({busy, frame_count}), 32'({1'b1, 8'd1}));
      if (cnt == 145) check("d2_after_end", 32'({busy, frame_count}), 32'({1'b0, 8'd2}));
    end
    @(posedge clk); #1; ena = 1'b1;

    // reset during the third data bit aborts the frame
    @(posedge clk); #1; req = 2'b01; nibble0 = 4'b0110; q0.push_back(4'b0110);
    @(negedge clk);
    @(posedge clk); #1; req = 2'b00;
    repeat (27) @(posedge clk);
    #2 check("d3_pre_reset", 32'({state_out, tx, frame_count}), 32'({2'd2, 1'b0, 8'd2}));
    rst_n = 1'b0;
    #1 check("d3_async_reset", 32'({tx, busy, state_out, gnt, frame_count}), 32'({1'b1, 1'b0, 2'd0, 2'b00, 8'd0}));
    q0.delete(); q1.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // both held after reset: 01, 10, 01, each 73 cycles apart
    @(posedge clk); #1;
    nibble0 = 4'($urandom); nibble1 = 4'b0001;
    q0.push_back(nibble0); q1.push_back(nibble1); req = 2'b11;
    grants = 0;
    for (int cnt = 0; cnt < 3 * FRAME_EDGES + 5 && grants < 3; cnt++) begin
      @(negedge clk);
      g = gnt;
      if (g != 2'b00) begin
        gseq[grants] = g; gtime[grants] = cnt; grants++;
        if (grants < 3) begin
          if (g[0]) q0.push_back(nibble0); else q1.push_back(nibble1);
        end
      end
      if (grants < 3) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1; req = 2'b00; q1.delete();
    check("rr_count", 32'(grants), 32'(3));
    if (grants == 3) begin
      check("rr_seq", 32'({gseq[0], gseq[1], gseq[2]}), 32'(6'b01_10_01));
      check("rr_gap1", 32'(gtime[1] - gtime[0]), 32'(FRAME_EDGES));
      check("rr_gap2", 32'(gtime[2] - gtime[1]), 32'(FRAME_EDGES));
    end
    drain();

    // requester 1 arrives mid-frame: no grant until the first IDLE cycle
    @(posedge clk); #1; ena = 1'b1; req = 2'b01; nibble0 = 4'($urandom); q0.push_back(nibble0);
    @(negedge clk); check("d4_gnt0", 32'(gnt), 32'(2'b01));
    early = 0;
    for (int cnt = 1; cnt <= 73; cnt++) begin
      @(posedge clk); #1;
      if (cnt == 1) req = 2'b00;
      if (cnt == 10) begin nibble1 = 4'($urandom); q1.push_back(nibble1); req = 2'b10; end
      @(negedge clk);
      if (cnt < 73 && gnt != 2'b00) early++;
      if (cnt == 73) check("d4_gnt1", 32'(gnt), 32'(2'b10));
    end
    check("d4_no_early_gnt", 32'(early), 32'(0));
    @(posedge clk); #1; req = 2'b00;
    drain();

    // random traffic with random ena and occasional withdrawals
    run_random(4000, 70, 15, 5);
    drain();

    // continuous traffic until frame_count has wrapped
    for (int n = 0; n < 300 * FRAME_EDGES && frames_done < 260; n++) run_random(1, 100, 100, 0);
    drain();
    repeat (2) @(negedge clk);
    check("wrap_reached", 32'(frames_done >= 256), 32'(1));
    check("wrap_count", 32'(frame_count), 32'(8'(frames_done)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
